matrix_operand_loader: RTL and testbench

//   Upstream stage of the 2x2 signed matrix multiplier. Accepts matrix elements one per

---
 rtl/matrix_operand_loader_if.sv | 24 ++
 rtl/matrix_operand_loader.sv | 93 +++++++++
 tb/tb_matrix_operand_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/matrix_operand_loader_if.sv
// Serial element stream in, parallel 2x2 operand pair out.
// slave = loader side, master = source/consumer side.
interface matrix_operand_loader_if #(
  parameter int ELEM_W = 4
);
  logic [ELEM_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] a00, a01, a10, a11;
  logic [ELEM_W-1:0] b00, b01, b10, b11;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        fill_cnt;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, a00, a01, a10, a11, b00, b01, b10, b11, out_valid, fill_cnt
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, a00, a01, a10, a11, b00, b01, b10, b11, out_valid, fill_cnt
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// Collects eight signed elements (a00..a11, b00..b11) one per beat and holds them
// stable for the matrix multiplier until the out handshake completes.
//
// state  | meaning
// S_LOAD | collecting elements, in_ready high unless rst/flush
// S_FULL | complete set presented, out_valid high, input stalled
module matrix_operand_loader #(
  parameter int ELEM_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  matrix_operand_loader_if.slave bus
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ELEM_W-1:0] elem_q [8];
  logic [3:0]        fill_q;
  logic              in_ready_c;
  logic              out_valid_c;
  logic              accept;
  logic              handoff;

  // The low three bits of the fill count double as the write index.
  assign accept  = bus.in_valid & in_ready_c;
  assign handoff = out_valid_c & bus.out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  if (accept && (fill_q[2:0] == 3'd7)) state_d = S_FULL;
        S_FULL:  if (bus.out_ready) state_d = S_LOAD;
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      S_LOAD:  in_ready_c  = ~rst & ~flush;
      S_FULL:  out_valid_c = 1'b1;
      default: in_ready_c  = 1'b0;
    endcase
  end

  // Operand storage is never cleared by flush or handoff; old values linger
  // until overwritten by the next set.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        elem_q[i] <= '0;
      end
    end else if (flush || handoff) begin
      fill_q <= 4'd0;
    end else if (accept) begin
      elem_q[fill_q[2:0]] <= bus.in_data;
      fill_q              <= fill_q + 4'd1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.fill_cnt  = fill_q;
  assign bus.a00 = elem_q[0];
  assign bus.a01 = elem_q[1];
  assign bus.a10 = elem_q[2];
  assign bus.a11 = elem_q[3];
  assign bus.b00 = elem_q[4];
  assign bus.b01 = elem_q[5];
  assign bus.b10 = elem_q[6];
  assign bus.b11 = elem_q[7];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: directed scenarios plus random traffic,
// every cycle compared against a set-level reference model.
module tb_matrix_operand_loader;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  matrix_operand_loader_if #(.ELEM_W(4)) bus();

  matrix_operand_loader #(.ELEM_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: how many elements of the current set are held, whether
  // the set is being presented, and the last value written to each slot
  int         m_cnt;
  bit         m_full;
  logic [3:0] m_elem [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_ops();
    return {bus.a00, bus.a01, bus.a10, bus.a11, bus.b00, bus.b01, bus.b10, bus.b11};
  endfunction

  function automatic logic [31:0] model_ops();
    return {m_elem[0], m_elem[1], m_elem[2], m_elem[3],
            m_elem[4], m_elem[5], m_elem[6], m_elem[7]};
  endfunction

  task automatic step(input bit do_chk);
    @(negedge clk);
    if (do_chk) begin
      chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, (!m_full && !rst && !flush)});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_full});
      chk("fill_cnt",  {28'd0, bus.fill_cnt},  m_cnt);
      chk("operands",  dut_ops(), model_ops());
    end
    @(posedge clk);
    if (rst) begin
      m_cnt  = 0;
      m_full = 0;
      for (int i = 0; i < 8; i++) m_elem[i] = 4'd0;
    end else if (flush) begin
      m_cnt  = 0;
      m_full = 0;
    end else if (m_full) begin
      if (bus.out_ready) begin
        m_full = 0;
        m_cnt  = 0;
      end
    end else if (bus.in_valid) begin
      m_elem[m_cnt] = bus.in_data;
      m_cnt++;
      if (m_cnt == 8) m_full = 1;
    end
    #1;
  endtask

  task automatic send(input logic [3:0] v);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    step(1);
    bus.in_valid = 1'b0;
    bus.in_data  = 'x;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
  endtask

  logic [3:0] t4_vals [8];
  logic [3:0] t5_vals [8];
  int         pulses[$];

  initial begin
    t4_vals = '{4'h8, 4'h7, 4'hF, 4'h0, 4'h8, 4'h8, 4'h7, 4'h7};
    t5_vals = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6};
    m_cnt  = 0;
    m_full = 0;
    for (int i = 0; i < 8; i++) m_elem[i] = 4'd0;

    // 1: reset held with a beat offered
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h5;
    bus.out_ready = 1'b0;
    step(0);
    step(1);
    step(1);
    chk("t1_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t1_ops", dut_ops(), 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 'x;
    step(1);

    // 2: basic back-to-back load
    for (int v = 1; v <= 8; v++) send(v[3:0]);
    chk("t2_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t2_ops", dut_ops(), 32'h12345678);
    chk("t2_fill", {28'd0, bus.fill_cnt}, 32'd8);
    chk("t2_in_ready", {31'd0, bus.in_ready}, 32'd0);

    // 3: backpressure, with a beat offered during the stall
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hA;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t3_hold", dut_ops(), 32'h12345678);
    end
    bus.in_valid = 1'b0;
    drain();
    chk("t3_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t3_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("t3_fill", {28'd0, bus.fill_cnt}, 32'd0);

    // 4: signed values with gaps
    for (int i = 0; i < 8; i++) begin
      send(t4_vals[i]);
      if (i < 7) repeat ($urandom_range(1, 3)) step(1);
    end
    chk("t4_ops", dut_ops(), 32'h87F08877);
    chk("t4_out_valid", {31'd0, bus.out_valid}, 32'd1);
    drain();

    // 5: flush mid-set, the flush-cycle beat is dropped
    for (int i = 0; i < 5; i++) send(4'($urandom));
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hC;
    step(1);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_fill_after_flush", {28'd0, bus.fill_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) send(t5_vals[i]);
    chk("t5_ops", dut_ops(), 32'h31415926);
    chk("t5_out_valid", {31'd0, bus.out_valid}, 32'd1);
    drain();

    // 6: streaming throughput
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.in_data = 4'($urandom);
      step(1);
      if (bus.out_valid) pulses.push_back(i);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("t6_pulse_count", pulses.size(), 32'd3);
    for (int k = 1; k < pulses.size(); k++)
      chk("t6_period", pulses[k] - pulses[k-1], 32'd9);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_data   = bus.in_valid ? 4'($urandom) : 4'bx;
      bus.out_ready = 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 31) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst          = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
